// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART program loader.
package loader_pkg;

    // Loader session states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Command byte that opens a load session
    localparam logic [7:0]  DEF_START_CMD = 8'h4C;

    // Instruction word that ends a load session
    localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into 32-bit words, MSB first, and flags each completed word.
module byte_assembler (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_last
);

    logic [1:0]  r_count;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Shift incoming bytes in; pulse word_valid the cycle after the 4th byte
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_count      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (i_valid) begin
            r_word       <= {r_word[23:0], i_byte};
            r_count      <= r_count + 2'd1;
            r_word_valid <= (r_count == 2'd3);
        end else begin
            r_word_valid <= 1'b0;
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    // The counter wraps to 0 on the 4th byte, so the next word starts clean
    // without an explicit clear during the write cycle.
    assign o_last       = (r_count == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// UART-side program loader: waits for a start command, assembles words and
// writes them to instruction memory, then releases the processor.
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 64,
    parameter logic [7:0]  START_CMD      = DEF_START_CMD,
    parameter logic [31:0] HALT_WORD      = DEF_HALT_WORD,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        write_instruction,
    output logic [31:0] address_instruction,
    output logic [31:0] instruction_receive,
    output logic        load_done,
    output logic        load_error,
    output logic        mips_enable
);

    localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AW-1:0] ADDR_LAST  = AW'(IMEM_DEPTH - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_timer;
    logic          r_done;
    logic          r_error;
    logic          w_start;
    logic          w_shift;
    logic          w_last;
    logic          w_word_valid;
    logic [31:0]   w_word;

    // A start command is only recognised outside an active session
    assign w_start = rx_done && (rx_data == START_CMD) &&
                     ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    // Bytes arriving during the write cycle belong to the next word
    assign w_shift = rx_done && ((r_state == ST_LOAD) || (r_state == ST_WRITE));

    byte_assembler u_asm (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (w_start),
        .i_valid      (w_shift),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last       (w_last)
    );

    // Session state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (rx_done) begin
                    if (w_last) w_state_next = ST_WRITE;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_WRITE: begin
                if (w_word == HALT_WORD)     w_state_next = ST_DONE;
                else if (r_addr == ADDR_LAST) w_state_next = ST_ERROR;
                else                          w_state_next = ST_LOAD;
            end
            ST_DONE:  w_state_next = ST_DONE;
            ST_ERROR: if (w_start) w_state_next = ST_LOAD;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Inter-byte idle timer: cleared by each byte, saturating otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= '0;
        end else if ((r_state == ST_LOAD) || (r_state == ST_WRITE)) begin
            if (rx_done)             r_timer <= '0;
            else if (r_timer != '1)  r_timer <= r_timer + TW'(1);
        end
    end

    // Word address: restarts at each session, advances after each non-final write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                   r_addr <= '0;
        else if (w_start)                                          r_addr <= '0;
        else if ((r_state == ST_WRITE) && (w_state_next == ST_LOAD)) r_addr <= r_addr + AW'(1);
    end

    // Registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= (w_state_next == ST_DONE);
            r_error <= (w_state_next == ST_ERROR);
        end
    end

    assign write_instruction   = w_word_valid;
    assign address_instruction = 32'(r_addr);
    assign instruction_receive = w_word;
    assign load_done           = r_done;
    assign load_error          = r_error;
    assign mips_enable         = r_done;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with IMEM_DEPTH=4 and TIMEOUT_CYCLES=100.
module tb_instr_loader;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        write_instruction;
    logic [31:0] address_instruction;
    logic [31:0] instruction_receive;
    logic        load_done;
    logic        load_error;
    logic        mips_enable;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] sq_addr[$];
    logic [31:0] sq_data[$];
    int          sq_cyc[$];
    bit          done_seen = 1'b0;
    int          done_cyc  = 0;

    instr_loader #(
        .IMEM_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_done             (rx_done),
        .rx_data             (rx_data),
        .write_instruction   (write_instruction),
        .address_instruction (address_instruction),
        .instruction_receive (instruction_receive),
        .load_done           (load_done),
        .load_error          (load_error),
        .mips_enable         (mips_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and the first cycle load_done is seen
    always @(negedge clk) begin
        if (write_instruction) begin
            sq_addr.push_back(address_instruction);
            sq_data.push_back(instruction_receive);
            sq_cyc.push_back(cyc);
        end
        if (load_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic chk_strobe(input int i, input logic [31:0] a, input logic [31:0] d, input string tag);
        if (sq_addr.size() > i) begin
            chk({tag, "_addr"}, sq_addr[i], a);
            chk({tag, "_data"}, sq_data[i], d);
        end else begin
            chk({tag, "_count"}, 32'(sq_addr.size()), 32'(i + 1));
        end
    endtask

    task automatic do_reset();
        rx_done = 1'b0;
        rst     = 1'b1;
        idle(2);
        rst     = 1'b0;
        sq_addr.delete();
        sq_data.delete();
        sq_cyc.delete();
        done_seen = 1'b0;
        idle(1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e);
        chk({tag, "_done"}, 32'(load_done), 32'(d));
        chk({tag, "_err"},  32'(load_error), 32'(e));
        chk({tag, "_mips"}, 32'(mips_enable), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        // Reset state
        idle(3);
        chk("rst_wr",   32'(write_instruction), 32'd0);
        chk("rst_addr", address_instruction, 32'd0);
        chk("rst_instr", instruction_receive, 32'd0);
        chk_status("rst", 1'b0, 1'b0);
        rst = 1'b0;
        idle(1);

        // Normal load
        send_byte(8'h4C);
        send_word(32'h1234_5678);
        send_word(32'h0000_0000);
        idle(3);
        chk("t1_count", 32'(sq_addr.size()), 32'd2);
        chk_strobe(0, 32'd0, 32'h1234_5678, "t1_w0");
        chk_strobe(1, 32'd1, 32'h0000_0000, "t1_w1");
        lat = (sq_cyc.size() >= 2 && done_seen) ? done_cyc - sq_cyc[1] : -1;
        chk("t1_done_lat", 32'(lat), 32'd1);
        chk_status("t1", 1'b1, 1'b0);

        // Preamble filtering
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(2);
        chk("t2_pre_count", 32'(sq_addr.size()), 32'd0);
        send_byte(8'h4C);
        send_word(32'hAABB_CCDD);
        send_word(32'h0000_0000);
        idle(3);
        chk("t2_count", 32'(sq_addr.size()), 32'd2);
        chk_strobe(0, 32'd0, 32'hAABB_CCDD, "t2_w0");
        chk_status("t2", 1'b1, 1'b0);

        // Overflow at depth 4, then restart
        do_reset();
        send_byte(8'h4C);
        for (int k = 0; k < 4; k++) send_word(32'(32'h1111_1111 * (k + 1)));
        idle(3);
        chk("t3_count", 32'(sq_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_strobe(k, 32'(k), 32'(32'h1111_1111 * (k + 1)), "t3_w");
        chk_status("t3", 1'b0, 1'b1);
        send_byte(8'h4C);
        idle(1);
        chk("t3_restart_err", 32'(load_error), 32'd0);
        send_word(32'hCAFE_F00D);
        idle(2);
        chk_strobe(4, 32'd0, 32'hCAFE_F00D, "t3_restart");
        send_word(32'h0000_0000);
        idle(2);
        chk_status("t3_end", 1'b1, 1'b0);

        // Timeout mid-word, then a clean restart
        do_reset();
        send_byte(8'h4C);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(95);
        chk("t4_early_err", 32'(load_error), 32'd0);
        idle(10);
        chk_status("t4", 1'b0, 1'b1);
        chk("t4_count", 32'(sq_addr.size()), 32'd0);
        send_byte(8'h4C);
        send_word(32'h0102_0304);
        send_word(32'h0000_0000);
        idle(3);
        chk_strobe(0, 32'd0, 32'h0102_0304, "t4_w0");
        chk_status("t4_end", 1'b1, 1'b0);

        // Back-to-back bytes on every cycle
        do_reset();
        send_byte(8'h4C);
        send_word(32'hA1B2_C3D4);
        send_word(32'h55AA_55AA);
        send_word(32'h0000_0000);
        idle(3);
        chk("t5_count", 32'(sq_addr.size()), 32'd3);
        chk_strobe(0, 32'd0, 32'hA1B2_C3D4, "t5_w0");
        chk_strobe(1, 32'd1, 32'h55AA_55AA, "t5_w1");
        chk_strobe(2, 32'd2, 32'h0000_0000, "t5_w2");
        lat = (sq_cyc.size() >= 3) ? sq_cyc[1] - sq_cyc[0] : -1;
        chk("t5_gap01", 32'(lat), 32'd4);
        lat = (sq_cyc.size() >= 3) ? sq_cyc[2] - sq_cyc[1] : -1;
        chk("t5_gap12", 32'(lat), 32'd4);
        chk_status("t5", 1'b1, 1'b0);

        // Reset mid-word, then a fresh session
        do_reset();
        send_byte(8'h4C);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("t6_partial", instruction_receive, 32'h0000_1122);
        rst = 1'b1;
        idle(1);
        chk("t6_wr",    32'(write_instruction), 32'd0);
        chk("t6_addr",  address_instruction, 32'd0);
        chk("t6_instr", instruction_receive, 32'd0);
        chk_status("t6_rst", 1'b0, 1'b0);
        rst = 1'b0;
        idle(1);
        chk("t6_none", 32'(sq_addr.size()), 32'd0);
        send_byte(8'h4C);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0000);
        idle(3);
        chk_strobe(0, 32'd0, 32'hDEAD_BEEF, "t6_w0");
        chk_strobe(1, 32'd1, 32'h0000_0000, "t6_w1");
        chk_status("t6_end", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
